// File: rtl/approx_pkg.sv
// Shared definitions for the approximate adder: mode encoding and a reference
// sum function usable by both the RTL and its scoreboards.
package approx_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Widest operand the reference function supports.
    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W:0] wide_t;

    // Reference sum for operand width w and k approximated LSBs. Operands must be
    // zero above bit w-1; the result occupies bits [w:0].
    function automatic wide_t approx_sum(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input logic             mode,
                                         input int unsigned      w,
                                         input int unsigned      k);
        wide_t exact;
        wide_t hi;
        wide_t res;
        logic  c;
        exact = {1'b0, a} + {1'b0, b};
        if (mode == MODE_EXACT || w == 0) begin
            return exact;
        end
        c   = (a[k-2] & a[k-1]) | (b[k-2] & b[k-1]);
        hi  = ({1'b0, a} >> k) + ({1'b0, b} >> k) + wide_t'(c);
        res = hi << k;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < k) begin
                res[i] = ~(a[i] & b[i]);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/approx_adder_pipe_lsb_gen.sv
// Approximate low field: NAND of each LSB pair plus a carry guessed from the
// top two approximated bit pairs.
module approx_lsb_gen
    import approx_pkg::*;
#(
    parameter int unsigned K = 2
) (
    input  logic [K-1:0] a_i,
    input  logic [K-1:0] b_i,
    output logic [K-1:0] sum_o,
    output logic         carry_o
);

    // NAND field and predicted carry into bit K
    always_comb begin
        sum_o   = ~(a_i & b_i);
        carry_o = (a_i[K-2] & a_i[K-1]) | (b_i[K-2] & b_i[K-1]);
    end

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined exact/approximate adder with valid/ready flow control and
// an in-line error monitor (accumulated, maximum and sample count).
module approx_adder_pipe
    import approx_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned K     = 2,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [W:0]       out_err,
    input  logic             stat_clr,
    output logic [ACC_W-1:0] err_acc,
    output logic [W:0]       err_max,
    output logic [CNT_W-1:0] samp_cnt
);

    // Wide enough to hold acc + err without wrapping before the saturation test.
    localparam int unsigned AccSumW = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;

    logic [W-1:0]     a1_q, b1_q;
    logic             mode1_q, v1_q;
    logic             out_valid_q;
    logic [W:0]       out_sum_q, out_err_q;
    logic [ACC_W-1:0] err_acc_q, err_acc_d;
    logic [W:0]       err_max_q, err_max_d;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;

    logic             en1, en2, xfer;
    logic [K-1:0]     lsb_sum;
    logic             lsb_carry;
    logic [W-K:0]     hi_sum;
    logic [W:0]       exact, approx, sum_d, err_d;
    logic [AccSumW-1:0] acc_ext;

    // Handshake: a stage advances when its successor is empty or draining
    always_comb begin
        en2      = !out_valid_q | out_ready;
        en1      = !v1_q | en2;
        in_ready = en1 & !rst;
        xfer     = out_valid_q & out_ready;
    end

    // Stage 1 operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= 1'b0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a1_q    <= in_a;
                b1_q    <= in_b;
                mode1_q <= in_mode;
            end
        end
    end

    approx_lsb_gen #(
        .K (K)
    ) u_lsb_gen (
        .a_i     (a1_q[K-1:0]),
        .b_i     (b1_q[K-1:0]),
        .sum_o   (lsb_sum),
        .carry_o (lsb_carry)
    );

    // Stage 2 sum selection and absolute error against the exact sum
    always_comb begin
        hi_sum = {1'b0, a1_q[W-1:K]} + {1'b0, b1_q[W-1:K]} + {{(W-K){1'b0}}, lsb_carry};
        approx = {hi_sum, lsb_sum};
        exact  = {1'b0, a1_q} + {1'b0, b1_q};
        sum_d  = (mode1_q == MODE_APPROX) ? approx : exact;
        err_d  = (exact >= sum_d) ? (exact - sum_d) : (sum_d - exact);
    end

    // Stage 2 result register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= '0;
        end else if (en2) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_sum_q <= sum_d;
                out_err_q <= err_d;
            end
        end
    end

    // Statistics next-state: saturating accumulate/count, running maximum
    always_comb begin
        err_acc_d  = err_acc_q;
        err_max_d  = err_max_q;
        samp_cnt_d = samp_cnt_q;
        acc_ext    = AccSumW'(err_acc_q) + AccSumW'(out_err_q);
        if (stat_clr) begin
            err_acc_d  = '0;
            err_max_d  = '0;
            samp_cnt_d = '0;
        end else if (xfer) begin
            if (acc_ext > AccSumW'({ACC_W{1'b1}})) begin
                err_acc_d = '1;
            end else begin
                err_acc_d = acc_ext[ACC_W-1:0];
            end
            if (samp_cnt_q != {CNT_W{1'b1}}) begin
                samp_cnt_d = samp_cnt_q + 1'b1;
            end
            if (out_err_q > err_max_q) begin
                err_max_d = out_err_q;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            err_acc_q  <= '0;
            err_max_q  <= '0;
            samp_cnt_q <= '0;
        end else begin
            err_acc_q  <= err_acc_d;
            err_max_q  <= err_max_d;
            samp_cnt_q <= samp_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;
    assign err_acc   = err_acc_q;
    assign err_max   = err_max_q;
    assign samp_cnt  = samp_cnt_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe (W=8, K=2, ACC_W=4 to reach saturation).
module tb_approx_adder_pipe;
    import approx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic        in_mode;
    logic        out_valid, out_ready;
    logic [8:0]  out_sum, out_err;
    logic        stat_clr;
    logic [3:0]  err_acc;
    logic [8:0]  err_max;
    logic [15:0] samp_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    approx_adder_pipe #(
        .W     (8),
        .K     (2),
        .ACC_W (4),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .stat_clr  (stat_clr),
        .err_acc   (err_acc),
        .err_max   (err_max),
        .samp_cnt  (samp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an empty pipeline with out_ready high; ends after the transfer edge.
    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic m, input logic [8:0] es, input logic [8:0] ee);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_mode   = m;
        tick();
        in_valid = 1'b0;
        check({tag, "_v_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_err"}, out_err, ee);
        tick();
    endtask

    initial begin
        logic [7:0] ba[10];
        logic [7:0] bb[10];
        logic       bm[10];
        logic [8:0] q_sum[$];
        logic [8:0] q_err[$];
        logic [8:0] e_sum, e_exact;
        int sent, got, outst, cyc;
        logic acc, xf;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
        out_ready = 1'b0; stat_clr = 1'b0;
        tick(); tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_err_acc", err_acc, 0);
        check("rst_samp_cnt", samp_cnt, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        run_vec("basic", 8'h03, 8'h03, MODE_APPROX, 9'h004, 9'd2);
        run_vec("zero_ap", 8'h00, 8'h00, MODE_APPROX, 9'h003, 9'd3);
        run_vec("zero_ex", 8'h00, 8'h00, MODE_EXACT, 9'h000, 9'd0);
        run_vec("cout_ap", 8'hFF, 8'h01, MODE_APPROX, 9'h102, 9'd2);
        run_vec("cout_ex", 8'hFF, 8'h01, MODE_EXACT, 9'h100, 9'd0);
        run_vec("mix_ex", 8'hA5, 8'h3C, MODE_EXACT, 9'h0E1, 9'd0);

        // Backpressure stream: out_ready low one cycle in three
        for (int i = 0; i < 10; i++) begin
            ba[i] = 8'($urandom_range(0, 255));
            bb[i] = 8'($urandom_range(0, 255));
            bm[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; outst = 0; cyc = 0;
        while (got < 10 && cyc < 200) begin
            out_ready = (cyc % 3 != 0);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                in_a    = ba[sent];
                in_b    = bb[sent];
                in_mode = bm[sent];
            end
            #1;
            check("bp_in_ready", in_ready, !(outst == 2 && !out_ready));
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                check("bp_no_dup", q_sum.size() > 0, 1);
                if (q_sum.size() > 0) begin
                    check("bp_sum", out_sum, q_sum.pop_front());
                    check("bp_err", out_err, q_err.pop_front());
                end
                got++;
            end
            if (acc) begin
                e_sum   = 9'(approx_sum(32'(ba[sent]), 32'(bb[sent]), bm[sent], 8, 2));
                e_exact = {1'b0, ba[sent]} + {1'b0, bb[sent]};
                q_sum.push_back(e_sum);
                q_err.push_back((e_exact >= e_sum) ? e_exact - e_sum : e_sum - e_exact);
                sent++;
            end
            outst = outst + int'(acc) - int'(xf);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_count", got, 10);
        tick();
        check("bp_drained", out_valid, 0);

        // Statistics with saturation
        out_ready = 1'b1;
        stat_clr  = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_acc", err_acc, 0);
        check("clr_max", err_max, 0);
        check("clr_cnt", samp_cnt, 0);
        for (int i = 1; i <= 6; i++) begin
            run_vec("stat", 8'h00, 8'h00, MODE_APPROX, 9'h003, 9'd3);
            check("stat_acc", err_acc, (3 * i > 15) ? 15 : 3 * i);
        end
        check("stat_max", err_max, 3);
        check("stat_cnt", samp_cnt, 6);

        // stat_clr coincident with a transfer wins
        in_valid = 1'b1; in_a = 8'h00; in_b = 8'h00; in_mode = MODE_APPROX;
        tick();
        in_valid = 1'b0;
        tick();
        check("clrx_pre_valid", out_valid, 1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clrx_acc", err_acc, 0);
        check("clrx_max", err_max, 0);
        check("clrx_cnt", samp_cnt, 0);

        // Reset during a full stall
        run_vec("pre_rst", 8'h00, 8'h00, MODE_APPROX, 9'h003, 9'd3);
        check("pre_rst_acc", err_acc, 3);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; in_mode = MODE_EXACT;
        tick();
        in_a = 8'h11;
        tick();
        in_valid = 1'b0;
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        check("stall_sum", out_sum, 9'h030);
        tick();
        check("stall_hold", out_sum, 9'h030);
        rst = 1'b1;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_sum", out_sum, 0);
        check("mrst_acc", err_acc, 0);
        check("mrst_max", err_max, 0);
        check("mrst_cnt", samp_cnt, 0);
        check("mrst_in_ready", in_ready, 0);
        rst = 1'b0;
        run_vec("post_rst", 8'h03, 8'h03, MODE_APPROX, 9'h004, 9'd2);
        check("post_rst_cnt", samp_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
